divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: start request, sampled on the rising edge of clk.
REQ-005 SHALL have port op1, input, DATA_WIDTH bits: unsigned dividend, sampled when a start is accepted.
REQ-006 SHALL have port op2, input, DATA_WIDTH bits: unsigned divisor, sampled when a start is accepted.
REQ-007 SHALL have port quot, output reg, DATA_WIDTH bits: quotient.
REQ-008 SHALL have port rem, output reg, DATA_WIDTH bits: remainder.
REQ-009 SHALL have port val, output reg, 1 bit: quot/rem/div_by_zero valid, one-cycle pulse.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port div_by_zero, output reg, 1 bit: the last completed operation had op2 == 0.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
REQ-013 SHALL accept a start only when state is IDLE and en == 1 at a rising edge, called edge E0; op1 and op2 are captured at E0.
REQ-014 SHALL ignore en while busy; operands presented then are not captured and SHALL NOT disturb the operation in flight.
REQ-015 SHALL transition IDLE->CALC at E0 if op2 != 0, or IDLE->DONE at E0 if op2 == 0.
REQ-016 SHALL perform, in CALC, one radix-2 restoring step per cycle: shift the partial remainder (DATA_WIDTH+1 bits) left, bring in the next dividend MSB, subtract the divisor if the result is non-negative, and shift the quotient bit in.
REQ-017 SHALL use an iteration counter that counts exactly DATA_WIDTH steps on edges E1..E(DATA_WIDTH), then transition CALC->DONE on edge E(DATA_WIDTH).
REQ-018 SHALL transition DONE->IDLE on the next edge, and SHALL update quot, rem and div_by_zero and set val=1 on that same edge; val SHALL be cleared on the following edge.
REQ-019 SHALL give a normal-operation latency of val high in the cycle after edge E0+DATA_WIDTH+1 (33 edges after E0 for the default width).
REQ-020 SHALL give a divide-by-zero latency of val high in the cycle after edge E0+2, with quot = all ones, rem = captured op1, and div_by_zero = 1.
REQ-021 SHALL, for op2 != 0, produce quot = floor(op1/op2) and rem = op1 - quot*op2, with rem < op2, and div_by_zero = 0.
REQ-022 SHALL hold quot, rem and div_by_zero stable between completions; they change only on the edge that sets val.
REQ-023 SHALL allow a new start at the first edge after val deasserts, since state is IDLE then; back-to-back operations have no additional gap.
REQ-024 SHALL keep busy combinational from state only, never from en.

Reset
REQ-025 SHALL, while rst_n == 0, asynchronously force state=IDLE, the counter to 0, quot=0, rem=0, val=0 and div_by_zero=0, so that busy=0.
REQ-026 SHALL, if reset is asserted mid-CALC or in DONE, abort the operation without producing a val pulse, and the first edge with rst_n == 1 and en == 1 SHALL be a valid E0.

Verification
REQ-027 SHALL verify op1=100, op2=7, en pulsed at E0 -> val is a single cycle after E0+33, quot=14, rem=2, div_by_zero=0.
REQ-028 SHALL verify op1=32'hFFFFFFFF, op2=1 -> quot=32'hFFFFFFFF, rem=0; and op1=7, op2=100 -> quot=0, rem=7.
REQ-029 SHALL verify op1=5, op2=0 -> val after E0+2, quot=32'hFFFFFFFF, rem=5, div_by_zero=1; a subsequent 9/3 gives quot=3, rem=0, div_by_zero=0.
REQ-030 SHALL verify a start of 100/7 with en held high and op1/op2 changed to 50/5 during CALC -> result is still 14/2, exactly one val pulse, then 50/5 is accepted at the first IDLE edge giving quot=10, rem=0.
REQ-031 SHALL verify rst_n pulled low at E0+10 of a 1000/3 operation -> all outputs are 0 immediately, there is no val, and a fresh 1000/3 gives quot=333, rem=1.
REQ-032 SHALL verify 1000 random operand pairs, including op2=1, op2=op1 and op1<op2, against a reference model of quotient and remainder, with busy high exactly from after E0 until the val edge.

Source files
------------

// File: rtl/divider.sv
// Multi-cycle unsigned divider: radix-2 restoring algorithm, one quotient bit per clock.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem,
  output logic                  val,
  output logic                  busy,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prem_q, prem_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic                  val_q, val_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;

  // acc holds the remaining dividend bits and collects quotient bits from the LSB end.
  assign shifted = {prem_q, acc_q[DATA_WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    val_d   = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          acc_d   = op1;
          dvs_d   = op2;
          prem_d  = '0;
          cnt_d   = '0;
          zero_d  = (op2 == '0);
          state_d = (op2 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        prem_d = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        acc_d  = {acc_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A zero divisor dwells one extra cycle here so its result lands two edges after the start.
        if (zero_q && cnt_q == '0) begin
          cnt_d = CW'(1);
        end else begin
          state_d = IDLE;
          val_d   = 1'b1;
          quot_d  = zero_q ? '1 : acc_q;
          rem_d   = zero_q ? acc_q : prem_q;
          dbz_d   = zero_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      val_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign val         = val_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);

endmodule
